uart_cmd_frame_parser: RTL
==========================

// Module: uart_cmd_frame_parser
// PURPOSE
//  Parametrised successor to the single-byte UART command decoder.
//  - Consumes bytes from the UART RX core and assembles framed commands:
//    HDR, OPC, ARG[0..ARG_BYTES-1], CHK.
//  - Checks each frame with an XOR checksum and decodes the opcode.
//  - Presents a sticky command code plus an argument word to the top-level
//    control FSM (calibration / A-D sampling / configuration).
//  - Adds inter-byte timeout recovery and error reporting.
// PARAMETERS
//  UART_NUM_DATA  8      UART data byte width
//  CMDLENGTH      4      width of decoded command code
//  ARG_BYTES      2      argument bytes per frame (>=1), MSB first
//  HDR_BYTE       8'hA5  frame start byte
//  TIMEOUT_CYC    1000   idle clk cycles tolerated between bytes inside a frame (>=2)
// PORTS
//  clk         in   1                        system clock
//  rst         in   1                        synchronous reset, active-high
//  sys_locked  in   1                        PLL lock; low acts as synchronous clear
//  uart_rdata  in   UART_NUM_DATA            received byte, valid with uart_vld
//  uart_vld    in   1                        1-cycle strobe per received byte
//  cmdout      out  CMDLENGTH                last accepted command code (sticky)
//  cmd_arg     out  ARG_BYTES*UART_NUM_DATA  last accepted argument word (sticky)
//  cmd_vld     out  1                        1-cycle pulse: new command accepted
//  err_chk     out  1                        1-cycle pulse: checksum mismatch
//  err_tout    out  1                        1-cycle pulse: inter-byte timeout
//  busy        out  1                        high while a frame is in progress (state != IDLE)
// BEHAVIOUR
//  Reset / clear
//  - Clock: one clock, clk; reset is synchronous and active-high, rst.
//  - Clear when rst=1 or sys_locked=0, at the next clk edge:
//    - state=IDLE, cmdout=0, cmd_arg=0, all pulses=0, busy=0,
//      timeout counter=0, checksum accumulator=0.
//    - Applies mid-frame: the partial frame is dropped and no error pulse is raised.
//  State machine
//  - All transitions occur only on cycles with uart_vld=1 (timeout excepted).
//  - IDLE: byte==HDR_BYTE -> OPC. Any other byte is ignored and the state stays IDLE.
//  - OPC: store the opcode; acc <= byte; arg index <= 0 -> ARGS.
//  - ARGS: shift the byte into the argument register, MSB first; acc ^= byte.
//    After the ARG_BYTES-th byte -> CHK.
//  - CHK, byte==acc:
//    - cmdout <= decode(opc), cmd_arg <= args.
//    - cmd_vld=1 for one cycle, on the edge after the CHK strobe (1-cycle latency).
//    - -> IDLE.
//  - CHK, byte!=acc: err_chk=1 for one cycle; cmdout and cmd_arg unchanged; -> IDLE.
//  - A byte equal to HDR_BYTE inside a frame is treated as data; there is no resync.
//  Decode
//  - 8'hCB -> 4'h1 (calibration); 8'hAD -> 4'h2 (A/D sample); 8'h5E -> 4'h3 (config write).
//  - Any other opcode -> 4'hF. It still asserts cmd_vld, and cmd_arg is updated.
//  - Codes are zero-extended or truncated to CMDLENGTH.
//  Timeout
//  - Counter is cleared in IDLE and on every uart_vld.
//  - Otherwise it increments each cycle while state!=IDLE, and saturates.
//  - On reaching TIMEOUT_CYC: err_tout=1 for one cycle and state -> IDLE.
//    cmdout and cmd_arg are unchanged.
//  - If uart_vld and expiry coincide, the byte wins: it is processed and the counter clears.
//  Outputs
//  - All outputs are registered.
//  - cmd_vld, err_chk and err_tout are mutually exclusive.
//  - uart_vld on back-to-back cycles is accepted, one byte per cycle.
// TESTING (ARG_BYTES=2, TIMEOUT_CYC=16 for bench)
//  1. Frame A5 CB 12 34 ED -> cmdout=1, cmd_arg=16'h1234, cmd_vld one pulse
//     one cycle after the ED strobe.
//  2. Frame A5 AD 00 00 AD, bytes back-to-back -> cmdout=2, cmd_arg=0, one cmd_vld.
//  3. Frame A5 CB 12 34 00 -> err_chk pulse; cmdout/cmd_arg keep prior values; busy=0 after.
//  4. Bytes 00 FF then A5 77 00 01 76 -> leading bytes ignored; cmdout=F,
//     cmd_arg=16'h0001, cmd_vld pulse.
//  5. A5 CB then 16 idle cycles -> err_tout pulse, busy=0.
//     Then a full case-1 frame -> accepted.
//     Byte arriving exactly on expiry cycle -> no err_tout.
//  6. rst=1, or sys_locked=0 for one cycle, after A5 CB 12 -> all outputs 0,
//     no pulses; a next full frame decodes normally.

Source files
------------

// File: rtl/uart_cmd_frame_parser.sv
// Purpose: assembles HDR/OPC/ARG../CHK byte frames from the UART RX core, XOR-checks them and decodes the opcode into a sticky command.
// Latency: cmd_vld / err_chk pulse one cycle after the CHK byte strobe; err_tout one cycle after the last idle cycle of the timeout window.
// Backpressure: none; one byte is accepted per uart_vld strobe, back-to-back strobes included.
module uart_cmd_frame_parser #(
  parameter int                         UART_NUM_DATA = 8,
  parameter int                         CMDLENGTH     = 4,
  parameter int                         ARG_BYTES     = 2,
  parameter logic [UART_NUM_DATA-1:0]   HDR_BYTE      = 8'hA5,
  parameter int                         TIMEOUT_CYC   = 1000
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 sys_locked,
  input  logic [UART_NUM_DATA-1:0]             uart_rdata,
  input  logic                                 uart_vld,
  output logic [CMDLENGTH-1:0]                 cmdout,
  output logic [ARG_BYTES*UART_NUM_DATA-1:0]   cmd_arg,
  output logic                                 cmd_vld,
  output logic                                 err_chk,
  output logic                                 err_tout,
  output logic                                 busy
);

  localparam int ARGW = ARG_BYTES * UART_NUM_DATA;
  localparam int TW   = $clog2(TIMEOUT_CYC + 1);
  localparam int IW   = (ARG_BYTES > 1) ? $clog2(ARG_BYTES) : 1;

  typedef enum logic [1:0] {IDLE, OPC, ARGS, CHK} state_t;

  state_t                   state, state_n;
  logic [UART_NUM_DATA-1:0] opc, acc;
  logic [ARGW-1:0]          args;
  logic [IW-1:0]            idx;
  logic [TW-1:0]            tcnt;
  logic                     clr, chk_ok, chk_bad, tout_hit;

  // Lost PLL lock is treated exactly like reset.
  assign clr = rst | ~sys_locked;

  // Unknown opcodes still produce a command, coded as all-ones nibble.
  function automatic logic [CMDLENGTH-1:0] decode(input logic [UART_NUM_DATA-1:0] op);
    logic [7:0] code;
    code = 8'h0F;
    if (op == UART_NUM_DATA'(8'hCB))      code = 8'h01;
    else if (op == UART_NUM_DATA'(8'hAD)) code = 8'h02;
    else if (op == UART_NUM_DATA'(8'h5E)) code = 8'h03;
    return CMDLENGTH'(code);
  endfunction

  // State register; clear forces IDLE and drops any partial frame silently.
  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_n;
  end

  // Next state and per-cycle event flags; a byte always wins over an expiring timeout.
  always_comb begin
    state_n  = state;
    chk_ok   = 1'b0;
    chk_bad  = 1'b0;
    tout_hit = 1'b0;
    if (uart_vld) begin
      case (state)
        IDLE:    if (uart_rdata == HDR_BYTE) state_n = OPC;
        OPC:     state_n = ARGS;
        ARGS:    if (idx == IW'(ARG_BYTES - 1)) state_n = CHK;
        CHK: begin
          state_n = IDLE;
          if (uart_rdata == acc) chk_ok  = 1'b1;
          else                   chk_bad = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end else if (state != IDLE && tcnt == TW'(TIMEOUT_CYC - 1)) begin
      tout_hit = 1'b1;
      state_n  = IDLE;
    end
  end

  // Datapath: frame capture, checksum, timeout counter and registered outputs.
  always_ff @(posedge clk) begin
    if (clr) begin
      opc      <= '0;
      acc      <= '0;
      args     <= '0;
      idx      <= '0;
      tcnt     <= '0;
      cmdout   <= '0;
      cmd_arg  <= '0;
      cmd_vld  <= 1'b0;
      err_chk  <= 1'b0;
      err_tout <= 1'b0;
      busy     <= 1'b0;
    end else begin
      cmd_vld  <= chk_ok;
      err_chk  <= chk_bad;
      err_tout <= tout_hit;
      busy     <= (state_n != IDLE);

      if (uart_vld || state == IDLE || tout_hit) tcnt <= '0;
      else if (tcnt < TW'(TIMEOUT_CYC))         tcnt <= tcnt + TW'(1);

      if (uart_vld) begin
        case (state)
          OPC: begin
            opc <= uart_rdata;
            acc <= uart_rdata;
            idx <= '0;
          end
          ARGS: begin
            // Shift in MSB first; written as shift/or so ARG_BYTES=1 needs no special slice.
            args <= (args << UART_NUM_DATA) | ARGW'(uart_rdata);
            acc  <= acc ^ uart_rdata;
            idx  <= idx + IW'(1);
          end
          CHK: begin
            if (chk_ok) begin
              cmdout  <= decode(opc);
              cmd_arg <= args;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
